// File: rtl/uart_rx_deframer.sv
// UART receive deframer: times each bit to its midpoint and assembles an LSB-first word.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 start_edge,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int H  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 samp;
  logic                 last_bit;

`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  // Start bit is sampled half a bit in; every later sample lands one full bit after the last.
  always_comb begin
    samp     = (state_q == START) ? (cnt_q == CW'(H - 1))
                                  : (cnt_q == CW'(CLKS_PER_BIT - 1));
    last_bit = (idx_q == IW'(DATA_BITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_edge && !rx) state_d = START;
      START:  if (samp) state_d = rx ? IDLE : DATA;
      DATA: begin
        if (samp && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (samp) state_d = STOP;
`endif
      STOP:   if (samp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (state_q == IDLE) begin
      cnt_d = '0;
      idx_d = '0;
`ifdef UART_RX_PARITY_EN
      par_d = 1'b0;
`endif
    end else begin
      cnt_d = samp ? '0 : cnt_q + CW'(1);
    end
    if (state_q == DATA && samp) begin
      sh_d  = {rx, sh_q[DATA_BITS-1:1]};
      idx_d = idx_q + IW'(1);
`ifdef UART_RX_PARITY_EN
      par_d = par_q ^ rx;
`endif
    end
`ifdef UART_RX_PARITY_EN
    if (state_q == PARITY && samp) par_d = par_q ^ rx;
`endif
    // A low stop bit outranks a parity mismatch; the word is published either way.
    if (state_q == STOP && samp) begin
      data_d = sh_q;
      if (!rx) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      else if (par_q) perr_d = 1'b1;
`endif
      else valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CLKS_PER_BIT=16, DATA_BITS=8.
// Honors UART_RX_PARITY_EN: every frame then carries an even-parity bit.
module tb_uart_rx_deframer;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 10 + P;
  localparam int LAT   = 153 + 16 * P;
  localparam int NCYC  = 160 + 16 * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic       start_edge = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  int checks = 0;
  int failures = 0;
  int vcnt, vat, fcnt, fat, pcnt, pat, bfall, bhigh;

  always #5 clk = ~clk;

  uart_rx_deframer #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .start_edge(start_edge),
    .data(data), .valid(valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [7:0] d, input logic par, input logic stop);
`ifdef UART_RX_PARITY_EN
    mk = {1'b1, stop, par, d, 1'b0};
`else
    mk = {2'b11, stop, d, 1'b0};
    if (par) mk = {2'b11, stop, d, 1'b0};
`endif
  endfunction

  // start_edge is sampled at edge t0 (j=0); observation after edge t0+j is cycle t0+j+1.
  task automatic run(input logic [11:0] frame, input int nb, input int bitlen, input int ncyc);
    int idx;
    vcnt = 0; vat = -1; fcnt = 0; fat = -1; pcnt = 0; pat = -1; bfall = -1; bhigh = 0;
    start_edge = 1'b1;
    rx = frame[0];
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk); #1;
      start_edge = 1'b0;
      if (valid)      begin vcnt++; vat = j + 1; end
      if (frame_err)  begin fcnt++; fat = j + 1; end
      if (parity_err) begin pcnt++; pat = j + 1; end
      if (busy) bhigh++;
      else if (bfall < 0) bfall = j + 1;
      idx = (j + 1) / bitlen;
      rx = (idx < nb) ? frame[idx] : 1'b1;
    end
  endtask

  initial begin
    // Asynchronous reset, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_data", 32'(data), 32'h00);
    chk("rst_async_valid", 32'(valid), 0);
    chk("rst_async_ferr", 32'(frame_err), 0);
    chk("rst_async_perr", 32'(parity_err), 0);
    chk("rst_async_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rel_data", 32'(data), 32'h00);
    chk("rst_rel_busy", 32'(busy), 0);
    chk("rst_rel_valid", 32'(valid), 0);

    // Good frame 0xA5
    run(mk(8'hA5, 1'b0, 1'b1), NBITS, C, NCYC);
    chk("good_vcnt", 32'(vcnt), 1);
    chk("good_vat", 32'(vat), 32'(LAT));
    chk("good_data", 32'(data), 32'hA5);
    chk("good_fcnt", 32'(fcnt), 0);
    chk("good_pcnt", 32'(pcnt), 0);
    chk("good_bfall", 32'(bfall), 32'(LAT));
    chk("good_bhigh", 32'(bhigh), 32'(LAT - 1));

    // False start: rx low for three cycles only
    run(12'hFF8, 12, 1, 20);
    chk("false_bhigh", 32'(bhigh), 8);
    chk("false_bfall", 32'(bfall), 9);
    chk("false_vcnt", 32'(vcnt), 0);
    chk("false_fcnt", 32'(fcnt), 0);
    chk("false_pcnt", 32'(pcnt), 0);
    chk("false_data", 32'(data), 32'hA5);

    // Framing error 0x3C
    run(mk(8'h3C, 1'b0, 1'b0), NBITS, C, NCYC);
    chk("ferr_fcnt", 32'(fcnt), 1);
    chk("ferr_fat", 32'(fat), 32'(LAT));
    chk("ferr_vcnt", 32'(vcnt), 0);
    chk("ferr_pcnt", 32'(pcnt), 0);
    chk("ferr_data", 32'(data), 32'h3C);

    // Back-to-back 0x00 then 0xFF, second start 8 cycles after the stop sample
    run(mk(8'h00, 1'b0, 1'b1), NBITS, C, NCYC);
    chk("b2b0_vcnt", 32'(vcnt), 1);
    chk("b2b0_data", 32'(data), 32'h00);
    run(mk(8'hFF, 1'b0, 1'b1), NBITS, C, NCYC);
    chk("b2b1_vcnt", 32'(vcnt), 1);
    chk("b2b1_vat", 32'(vat), 32'(LAT));
    chk("b2b1_data", 32'(data), 32'hFF);

    // Reset in the middle of a frame
    run(mk(8'h5A, 1'b0, 1'b1), NBITS, C, 60);
    chk("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data), 32'h00);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_ferr", 32'(frame_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx = 1'b1;
    vcnt = 0; bhigh = 0;
    for (int j = 0; j < 200; j++) begin
      @(posedge clk); #1;
      if (valid || frame_err || parity_err) vcnt++;
      if (busy) bhigh++;
    end
    chk("post_rst_pulses", 32'(vcnt), 0);
    chk("post_rst_busy", 32'(bhigh), 0);
    chk("post_rst_data", 32'(data), 32'h00);

`ifdef UART_RX_PARITY_EN
    // 0x01 with parity bit 1 is even overall; parity bit 0 is a mismatch
    run(mk(8'h01, 1'b1, 1'b1), NBITS, C, NCYC);
    chk("par_ok_vcnt", 32'(vcnt), 1);
    chk("par_ok_vat", 32'(vat), 169);
    chk("par_ok_pcnt", 32'(pcnt), 0);
    run(mk(8'h01, 1'b0, 1'b1), NBITS, C, NCYC);
    chk("par_bad_pcnt", 32'(pcnt), 1);
    chk("par_bad_pat", 32'(pat), 169);
    chk("par_bad_vcnt", 32'(vcnt), 0);
    chk("par_bad_data", 32'(data), 32'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial receive framer for the UART path. It sits directly downstream of the falling-edge detector on the synchronized RX line, which supplies the start-edge pulse. It times each bit to its midpoint and assembles an LSB-first byte. It emits one-cycle result pulses for a good frame, a framing error or (optionally) a parity error.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit; must be ≥ 4. H = CLKS_PER_BIT/2, integer division.
- DATA_BITS, 8: data bits per frame, 5..9.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rx  input  1  serial line, already synchronized to clk; idle high.
- start_edge  input  1  one-cycle pulse marking a falling edge on rx, from the upstream edge detector.
- data  output  DATA_BITS  last received byte, LSB = first data bit on the line.
- valid  output  1  one-cycle pulse: good frame, data updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when parity is compiled out.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. Two counters:
  - bit-timing counter, width $clog2(CLKS_PER_BIT);
  - bit index, width $clog2(DATA_BITS+1).
- IDLE: on start_edge=1 with rx=0, go to START and clear the timing counter. start_edge with rx=1 is ignored.
- START: wait until the start-bit midpoint, then sample rx.
  - rx=1: false start; return to IDLE with no output pulse.
  - rx=0: go to DATA.
- DATA: sample once per bit at each bit midpoint and shift in LSB-first. After DATA_BITS samples, go to PARITY if enabled, otherwise STOP.
- PARITY: sample one bit at its midpoint, then go to STOP.
- STOP: sample at its midpoint, then return to IDLE on the same edge. The remaining half stop bit is not waited out, so a new start_edge is accepted immediately.
- Stop sample result:
  - rx=1 and no parity error: data updates and valid pulses.
  - rx=0: data updates, frame_err pulses, valid stays 0. Framing error takes precedence over parity error; only frame_err pulses.
- start_edge is ignored in every state other than IDLE.
- Output pulses are mutually exclusive and at most one per frame.
- Reset, asserted asynchronously at any time including mid-frame:
  - state IDLE, counters 0, shift register 0;
  - data=0, valid=0, frame_err=0, parity_err=0, busy=0.
  - After release, the partial frame is discarded; reception resumes only on the next start_edge.

## Timing
- Let t0 be the cycle in which start_edge is accepted. busy is high from t0+1 until the cycle the FSM re-enters IDLE.
- Sample instants are t0 + H + k·CLKS_PER_BIT:
  - k=0: start bit;
  - k=1..DATA_BITS: data bits;
  - k=DATA_BITS+1: parity bit, if enabled;
  - last k: stop bit.
- valid, frame_err and parity_err are registered and high for exactly the one cycle following the stop sample.
- data changes in that same cycle and holds until the next frame's result.
- Total latency with parity off: t0 + H + (DATA_BITS+1)·CLKS_PER_BIT + 1. Add CLKS_PER_BIT with parity on.
- Counter wraps exactly at CLKS_PER_BIT−1; no cumulative drift over the frame.

## Configuration
- UART_RX_PARITY_EN defined:
  - one even-parity bit is expected between the last data bit and the stop bit;
  - mismatch when XOR(data bits, parity bit) = 1;
  - on mismatch with a valid stop bit: parity_err pulses, valid stays 0, data still updates.
- UART_RX_PARITY_EN undefined:
  - no PARITY state; DATA goes straight to STOP;
  - parity_err is tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, so H=8.
- Reset: drive rst_n=0 with rx=1 → data=0x00, valid=0, frame_err=0, parity_err=0, busy=0. Check this both asynchronously (before any clk edge) and after release.
- Good frame, parity off: send 0xA5 with start_edge at t0 → valid high only at t0+153, data=0xA5, busy low from t0+153.
- False start: rx low for 3 cycles with a start_edge → FSM returns to IDLE at the t0+8 sample, busy high only t0+1..t0+8, no pulse, data unchanged.
- Framing error: send 0x3C with stop bit 0 → frame_err high at t0+153, valid=0, data=0x3C.
- Back-to-back: 0x00 then 0xFF, with the second start_edge 8 cycles after the first stop sample → two valid pulses, data 0x00 then 0xFF. Also assert rst_n mid-second-frame → all outputs 0 and no valid.
- Parity (macro defined): 0x01 with parity bit 1 → valid at t0+169. 0x01 with parity bit 0 → parity_err at t0+169, valid=0.
